// File: rtl/mem_access_scheduler.sv
// Single-port memory sequencer shared by fetch and load/store.
// One outstanding req/gnt + rvalid transaction, data side has priority.
module mem_access_scheduler #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              bus_err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;
    typedef enum logic {FETCH, DATA} owner_t;

    state_t             state;
    state_t             state_n;
    owner_t             owner;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  if_rdata_q;
    logic [DATA_W-1:0]  dm_rdata_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               busy;
    logic               timeout;
    logic               dm_any;
    logic               err_q;

    assign dm_any  = dm_read | dm_write;
    assign busy    = (state == REQ) || (state == RSP);
    assign cnt_inc = cnt + CNT_W'(1);
    // cnt holds cycles already spent busy; fire as this cycle completes TIMEOUT
    assign timeout = (TIMEOUT != 0) && busy && (cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (dm_any || if_req) state_n = REQ;
            end
            REQ: begin
                if (timeout) begin
                    state_n = DONE;
                end else if (mem_gnt) begin
                    state_n = we_q ? DONE : RSP;
                end
            end
            RSP: begin
                if (timeout || mem_rvalid) state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= FETCH;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (dm_any) begin
                        owner   <= DATA;
                        addr_q  <= dm_addr;
                        wdata_q <= dm_wdata;
                        we_q    <= dm_write;
                    end else if (if_req) begin
                        owner  <= FETCH;
                        addr_q <= if_addr;
                        we_q   <= 1'b0;
                    end
                end
                REQ, RSP: begin
                    cnt <= cnt_inc;
                    if (timeout) begin
                        err_q <= 1'b1;
                        if (owner == DATA) dm_rdata_q <= '0;
                        else               if_rdata_q <= '0;
                    end else if (state == RSP && mem_rvalid) begin
                        if (owner == DATA) dm_rdata_q <= mem_rdata;
                        else               if_rdata_q <= mem_rdata;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign mem_req   = (state == REQ);
    assign mem_we    = (state == REQ) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_done   = (state == DONE) && (owner == FETCH);
    assign dm_done   = (state == DONE) && (owner == DATA);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign bus_err   = err_q;
    assign stall     = (dm_any & ~dm_done) | (if_req & ~if_done);

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Randomized transaction bench for mem_access_scheduler with a
// cycle-schedule reference model and a TIMEOUT=4 watchdog instance.
module tb_mem_access_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        dm_read = 1'b0;
    logic        dm_write = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_done, dm_done, mem_req, mem_we, stall, bus_err;

    logic        t_if_req = 1'b0;
    logic        t_dm_read = 1'b0;
    logic [31:0] t_addr = '0;
    logic        t_gnt = 1'b0;
    logic        t_rvalid = 1'b0;
    logic [31:0] t_rdata = '0;
    logic [31:0] t_if_rdata, t_dm_rdata, t_mem_addr, t_mem_wdata;
    logic        t_if_done, t_dm_done, t_mem_req, t_mem_we, t_stall, t_bus_err;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] m_if = '0;
    logic [31:0] m_dm = '0;
    bit t_berr = 1'b0;

    always #5 clk = ~clk;

    mem_access_scheduler dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_done(if_done),
        .dm_read(dm_read), .dm_write(dm_write),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .stall(stall), .bus_err(bus_err)
    );

    mem_access_scheduler #(.TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset),
        .if_req(t_if_req), .if_addr(t_addr),
        .if_rdata(t_if_rdata), .if_done(t_if_done),
        .dm_read(t_dm_read), .dm_write(1'b0),
        .dm_addr(t_addr), .dm_wdata(32'h0),
        .dm_rdata(t_dm_rdata), .dm_done(t_dm_done),
        .mem_req(t_mem_req), .mem_we(t_mem_we),
        .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
        .mem_gnt(t_gnt), .mem_rvalid(t_rvalid),
        .mem_rdata(t_rdata), .stall(t_stall), .bus_err(t_bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // One transaction from its IDLE cycle (k=0, caller already at negedge)
    // through DONE (k=len). Read: done = gw+rw+3, write: done = gw+2.
    task automatic serve(input bit dat, input bit we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int gw, input int rw);
        int len;
        bit in_req;
        bit fin;
        bit exp_stall;
        len = we ? gw + 2 : gw + rw + 3;
        for (int k = 0; k <= len; k++) begin
            if (k > 0) @(negedge clk);
            mem_gnt = (k == gw + 1);
            mem_rvalid = 1'b0;
            if (k >= 1 && k <= gw + 1) mem_rvalid = 1'($urandom_range(0, 1));
            if (!we && k == gw + 2 + rw) mem_rvalid = 1'b1;
            mem_rdata = (!we && k == gw + 2 + rw) ? rd : $urandom;
            if (dat && k > 0) begin
                dm_addr = $urandom;
                dm_wdata = $urandom;
            end
            #1;
            in_req = (k >= 1 && k <= gw + 1);
            fin = (k == len);
            chk("mem_req", 32'(mem_req), 32'(in_req));
            if (in_req) begin
                chk("mem_addr", mem_addr, addr);
                chk("mem_we", 32'(mem_we), 32'(we));
                if (we) chk("mem_wdata", mem_wdata, wd);
            end
            chk("if_done", 32'(if_done), 32'(!dat && fin));
            chk("dm_done", 32'(dm_done), 32'(dat && fin));
            exp_stall = ((dm_read || dm_write) && !(dat && fin)) ||
                        (if_req && !(!dat && fin));
            chk("stall", 32'(stall), 32'(exp_stall));
            if (fin) begin
                if (!we) begin
                    if (dat) m_dm = rd;
                    else     m_if = rd;
                end
                chk("if_rdata", if_rdata, m_if);
                chk("dm_rdata", dm_rdata, m_dm);
                chk("bus_err", 32'(bus_err), 32'(0));
            end
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (dat) begin
            dm_read = 1'b0;
            dm_write = 1'b0;
        end else begin
            if_req = 1'b0;
        end
    endtask

    // kind: 0 load, 1 store, 2 both strobes (store must win)
    task automatic round(input bit use_dm, input int kind, input bit use_if,
                         input logic [31:0] da, input logic [31:0] dw,
                         input logic [31:0] drd, input logic [31:0] ia,
                         input logic [31:0] ird, input int dgw, input int drw,
                         input int igw, input int irw);
        @(negedge clk);
        if (use_dm) begin
            dm_read = (kind != 1);
            dm_write = (kind != 0);
            dm_addr = da;
            dm_wdata = dw;
        end
        if (use_if) begin
            if_req = 1'b1;
            if_addr = ia;
        end
        if (use_dm) begin
            serve(1'b1, kind != 0, da, dw, drd, dgw, drw);
            if (use_if) @(negedge clk);
        end
        if (use_if) serve(1'b0, 1'b0, ia, 32'h0, ird, igw, irw);
    endtask

    // Reads on the TIMEOUT=4 instance; gw < 0 means the grant never comes.
    task automatic t_txn(input bit dat, input logic [31:0] addr,
                         input logic [31:0] rd, input int gw);
        int len;
        int last_req;
        len = (gw < 0) ? 5 : gw + 3;
        last_req = (gw < 0) ? 4 : gw + 1;
        @(negedge clk);
        if (dat) t_dm_read = 1'b1;
        else     t_if_req = 1'b1;
        t_addr = addr;
        for (int k = 0; k <= len; k++) begin
            if (k > 0) @(negedge clk);
            t_gnt = (gw >= 0 && k == gw + 1);
            t_rvalid = (gw >= 0 && k == gw + 2);
            t_rdata = t_rvalid ? rd : 32'h0;
            #1;
            chk("t_mem_req", 32'(t_mem_req), 32'(k >= 1 && k <= last_req));
            chk("t_done", 32'(dat ? t_dm_done : t_if_done), 32'(k == len));
            chk("t_bus_err", 32'(t_bus_err), 32'(t_berr || (gw < 0 && k == len)));
        end
        chk("t_rdata", dat ? t_dm_rdata : t_if_rdata, (gw < 0) ? 32'h0 : rd);
        if (gw < 0) t_berr = 1'b1;
        t_gnt = 1'b0;
        t_rvalid = 1'b0;
        t_dm_read = 1'b0;
        t_if_req = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'(0));
        chk("rst_mem_we", 32'(mem_we), 32'(0));
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_if_done", 32'(if_done), 32'(0));
        chk("rst_dm_done", 32'(dm_done), 32'(0));
        chk("rst_bus_err", 32'(bus_err), 32'(0));
        chk("rst_stall", 32'(stall), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        round(0, 0, 1, 0, 0, 0, 32'h40, 32'h00500093, 0, 0, 0, 0);
        round(1, 1, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 2, 0, 0, 0);
        round(1, 0, 1, 32'h200, 0, 32'h11112222, 32'h44, 32'h33334444,
              0, 0, 0, 0);
        round(1, 2, 0, 32'h300, 32'hA5A5A5A5, 0, 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            bit ud;
            bit ui;
            int gap;
            ud = 1'($urandom_range(0, 1));
            ui = ud ? 1'($urandom_range(0, 1)) : 1'b1;
            round(ud, int'($urandom_range(0, 2)), ui, $urandom, $urandom,
                  $urandom, $urandom, $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                #1;
                chk("gap_mem_req", 32'(mem_req), 32'(0));
                chk("gap_stall", 32'(stall), 32'(0));
            end
        end

        // Abort a fetch while it waits in RSP.
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 32'h80;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        chk("abort_req", 32'(mem_req), 32'(1));
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("abort_mem_req", 32'(mem_req), 32'(0));
        chk("abort_mem_we", 32'(mem_we), 32'(0));
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_if_rdata", if_rdata, 32'h0);
        chk("abort_dm_rdata", dm_rdata, 32'h0);
        chk("abort_if_done", 32'(if_done), 32'(0));
        chk("abort_dm_done", 32'(dm_done), 32'(0));
        m_if = '0;
        m_dm = '0;
        @(negedge clk);
        #1;
        chk("abort_hold_done", 32'(if_done), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        serve(1'b0, 1'b0, 32'h80, 32'h0, 32'h0BADF00D, 0, 0);

        t_txn(1'b1, 32'h300, 32'hCAFEF00D, 0);
        t_txn(1'b1, 32'h304, 32'h0, -1);
        t_txn(1'b0, 32'h308, 32'h12345678, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_scheduler.md
# mem_access_scheduler

Sequences a single shared memory port between instruction fetch and the load/store path of the RISC-V core. Accepts level requests from fetch and from the data side, issues one transaction at a time on a req/gnt + rvalid memory interface, and returns data with one-cycle done pulses. A watchdog times out stuck transactions. Its `stall` output freezes the pipeline while either requester is waiting.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles a transaction may spend in REQ+RSP; 0 disables watchdog
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request, level; held until if_done
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_rdata  out  DATA_W  fetched word, valid when if_done
- if_done  out  1  one-cycle fetch completion pulse
- dm_read  in  1  load request (MemRead), level
- dm_write  in  1  store request (MemWrite), level; wins if both high
- dm_addr  in  ADDR_W  data address (ALU result)
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid when dm_done
- dm_done  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data
- stall  out  1  pipeline hold, combinational
- bus_err  out  1  sticky timeout flag

## Operation
- Owner register: FETCH or DATA. Only one transaction is outstanding at a time.
- States: IDLE, REQ, RSP, DONE.
- IDLE:
  - If dm_read|dm_write, set owner=DATA, capture dm_addr/dm_wdata, set mem_we=dm_write, go to REQ.
  - Else if if_req, set owner=FETCH, capture if_addr, set mem_we=0, go to REQ.
  - Data has fixed priority because it belongs to the older instruction.
- REQ: mem_req=1, addr/wdata/we held constant.
  - On mem_gnt with a write, go to DONE.
  - On mem_gnt with a read, go to RSP.
  - mem_rvalid is ignored in REQ.
- RSP: on mem_rvalid, capture mem_rdata into the owner's rdata register and go to DONE.
- DONE: pulse the owner's done for exactly one cycle, no arbitration, then go to IDLE. This stops a request that is still high during the done cycle from being reissued.
- Watchdog:
  - Counter of width $clog2(TIMEOUT+1). Cleared in IDLE/DONE; increments each cycle in REQ/RSP.
  - When it reaches TIMEOUT (TIMEOUT≠0), go to DONE, load rdata=0, set bus_err=1.
  - bus_err is cleared only by reset.
- stall = ((dm_read|dm_write) & ~dm_done) | (if_req & ~if_done).
- rdata registers hold their value until the next completion for the same owner.

## Timing
- Reset (async, immediate): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_done=0, dm_done=0, bus_err=0, counter=0.
- Reset mid-transaction aborts it. No done pulse is produced. The memory must tolerate a dropped mem_req.
- mem_req, mem_we and the done pulses are decoded from registered state and owner, so they are glitch-free.
- Read latency with zero-wait memory: request seen in IDLE at cycle 0, REQ+gnt at cycle 1, RSP+rvalid at cycle 2, done at cycle 3. Each gnt or rvalid wait cycle adds 1.
- Write latency with zero-wait memory: IDLE at 0, REQ+gnt at 1, done at 2.
- Back-to-back: the next arbitration happens in the IDLE cycle after DONE, so minimum spacing is 4 cycles per read and 3 per write.
- Simultaneous dm and if requests in IDLE: DATA is served first. FETCH is served after the DATA done, provided if_req is still high.
- A requester dropping its request before done is illegal. The transaction completes anyway.

## Test plan
- Single fetch, addr 0x40, gnt immediate, rvalid at cycle 2 with 0x00500093 -> if_done at cycle 3, if_rdata=0x00500093, stall high cycles 0–2 and low at cycle 3.
- Store, addr 0x100, data 0xDEADBEEF, gnt delayed 2 cycles -> mem_req held 3 cycles with mem_we=1 and addr/data stable, dm_done 1 cycle after gnt, no RSP state.
- if_req and dm_read both asserted at cycle 0 -> data transaction first (dm_done at cycle 3), fetch mem_req at cycle 5, if_done at cycle 7.
- dm_read and dm_write both high -> write issued (mem_we=1).
- TIMEOUT=4, gnt never asserted -> done pulse after 4 REQ cycles, rdata=0, bus_err=1 and stays 1 through later successful transactions.
- Reset asserted while in RSP -> mem_req=0 and all outputs 0 immediately, no done pulse. After release, a pending if_req restarts from IDLE.
